mux_lut_array: RTL and testbench

//  Array of CHANNELS programmable logic cells. Each cell is a 2**N_IN:1 mux tree

---
 rtl/mux_lut_array.sv | 124 ++++++++++++
 tb/tb_mux_lut_array.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_lut_array.sv
// mux_lut_array: array of serially configured lookup cells, each a tree of 2:1 muxes
// selecting one constant truth-table bit, applied to a registered valid-qualified stream.

module mux2 (
    input  logic a,
    input  logic b,
    input  logic s,
    output logic y
);
    assign y = s ? b : a;
endmodule

module mux_lut_array #(
    parameter int N_IN     = 1,
    parameter int CHANNELS = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_valid,
    input  logic                     cfg_data,
    output logic                     cfg_ready,
    input  logic                     cfg_clear,
    output logic                     configured,
    input  logic                     in_valid,
    input  logic [CHANNELS*N_IN-1:0] in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [CHANNELS-1:0]      out_data
);
    localparam int LEAVES   = 2 ** N_IN;
    localparam int CFG_BITS = CHANNELS * LEAVES;
    localparam int CW       = $clog2(CFG_BITS + 1);

    typedef enum logic [1:0] {EMPTY, LOAD, RUN} state_t;

    state_t                state_q, state_d;
    logic [CFG_BITS-1:0]   truth_q;
    logic [CFG_BITS-1:0]   truth_shift;
    logic [CW-1:0]         cnt_q;
    logic                  cfg_beat;
    logic                  last_beat;
    logic                  run_beat;
    logic [CHANNELS-1:0]   cell_out;

    assign cfg_ready  = (state_q != RUN);
    assign in_ready   = (state_q == RUN);
    assign configured = (state_q == RUN);

    // cfg_clear wins over any same-cycle config or data beat
    assign cfg_beat  = cfg_valid && cfg_ready && !cfg_clear;
    assign last_beat = cfg_beat && (cnt_q == CW'(CFG_BITS - 1));
    assign run_beat  = in_valid && in_ready && !cfg_clear;

    // shift-in path: first bit sent ends at the MSB
    if (CFG_BITS > 1) begin : g_shift
        assign truth_shift = {truth_q[CFG_BITS-2:0], cfg_data};
    end else begin : g_shift1
        assign truth_shift = cfg_data;
    end

    // Mux tree per cell. node[] holds all tree levels back to back: leaves first,
    // then each halving level; level l starts at 2*LEAVES - (2*LEAVES >> l), root last.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_cell
        logic [2*LEAVES-2:0] node;
        assign node[LEAVES-1:0] = truth_q[c*LEAVES +: LEAVES];
        for (genvar l = 0; l < N_IN; l++) begin : g_lvl
            localparam int SRC = 2*LEAVES - ((2*LEAVES) >> l);
            localparam int DST = 2*LEAVES - (LEAVES >> l);
            for (genvar j = 0; j < (LEAVES >> (l + 1)); j++) begin : g_mux
                mux2 u_mux (
                    .a (node[SRC + 2*j]),
                    .b (node[SRC + 2*j + 1]),
                    .s (in_data[c*N_IN + l]),
                    .y (node[DST + j])
                );
            end
        end
        assign cell_out[c] = node[2*LEAVES-2];
    end

    // next-state logic for the configuration FSM
    always_comb begin
        state_d = state_q;
        if (cfg_clear) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY:   if (cfg_beat) state_d = last_beat ? RUN : LOAD;
                LOAD:    if (last_beat) state_d = RUN;
                RUN:     state_d = RUN;
                default: state_d = EMPTY;
            endcase
        end
    end

    // state, truth table and bit counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            truth_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (cfg_clear) begin
                truth_q <= '0;
                cnt_q   <= '0;
            end else if (cfg_beat) begin
                truth_q <= truth_shift;
                cnt_q   <= last_beat ? '0 : cnt_q + CW'(1);
            end
        end
    end

    // registered result: one-cycle valid pulse per accepted beat, data held otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= run_beat;
            if (run_beat) out_data <= cell_out;
        end
    end
endmodule

// File: tb/tb_mux_lut_array.sv
// tb_mux_lut_array: randomized self-checking bench for mux_lut_array against a
// truth-table indexing model (2-input/2-channel instance plus a 1-input NOT cell).

module tb_mux_lut_array;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       cfg_valid, cfg_data, cfg_clear, in_valid;
    logic [3:0] in_data;
    logic       cfg_ready, configured, in_ready, out_valid;
    logic [1:0] out_data;

    logic       b_cfg_valid, b_cfg_data, b_cfg_clear, b_in_valid;
    logic [0:0] b_in_data;
    logic       b_cfg_ready, b_configured, b_in_ready, b_out_valid;
    logic [0:0] b_out_data;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    logic [1:0]  exp_out;

    mux_lut_array #(.N_IN(2), .CHANNELS(2)) u_dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
        .cfg_clear(cfg_clear), .configured(configured),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data)
    );

    mux_lut_array #(.N_IN(1), .CHANNELS(1)) u_not (
        .clk(clk), .rst(rst),
        .cfg_valid(b_cfg_valid), .cfg_data(b_cfg_data), .cfg_ready(b_cfg_ready),
        .cfg_clear(b_cfg_clear), .configured(b_configured),
        .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_data(b_out_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // out[c] is bit (c*4 + sel_c) of the 8-bit table, sel_c = in[2c+1:2c]
    function automatic logic [1:0] model(input logic [7:0] t, input logic [3:0] v);
        logic [1:0] r;
        for (int c = 0; c < 2; c++) begin
            int sel;
            sel  = (int'(v) >> (2 * c)) & 3;
            r[c] = t[c*4 + sel];
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // send t MSB first, with 'gap' idle cycles before each bit
    task automatic load(input logic [7:0] t, input int gap, input logic hold_in);
        for (int i = 7; i >= 0; i--) begin
            for (int g = 0; g < gap; g++) begin
                cfg_valid = 1'b0;
                step();
                check("gap_configured", configured, 0);
            end
            cfg_valid = 1'b1;
            cfg_data  = t[i];
            check("load_cfg_ready", cfg_ready, 1);
            check("load_configured", configured, 0);
            if (hold_in) check("load_no_out", out_valid, 0);
            step();
        end
        cfg_valid = 1'b0;
        check("cfg_configured", configured, 1);
        check("cfg_ready_run", cfg_ready, 0);
        check("in_ready_run", in_ready, 1);
        if (hold_in) check("last_load_no_out", out_valid, 0);
    endtask

    task automatic run_random(input logic [7:0] t, input int n);
        for (int k = 0; k < n; k++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 4'($urandom);
            if (in_valid) exp_out = model(t, in_data);
            step();
            check("rand_valid", out_valid, in_valid);
            check("rand_data", out_data, exp_out);
        end
        in_valid = 1'b0;
    endtask

    task automatic check_reset_a();
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_configured", configured, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
    endtask

    initial begin
        logic [7:0] t1, t2, t3;
        rst = 1'b1;
        {cfg_valid, cfg_data, cfg_clear, in_valid} = '0;
        in_data = '0;
        {b_cfg_valid, b_cfg_data, b_cfg_clear, b_in_valid} = '0;
        b_in_data = '0;
        exp_out = '0;
        #12;
        check_reset_a();
        check("rst_b_cfg_ready", b_cfg_ready, 1);
        check("rst_b_out_valid", b_out_valid, 0);
        step();
        rst = 1'b0;
        step();

        // 1-input NOT cell: bits 0 then 1 give truth 2'b01
        b_cfg_valid = 1'b1; b_cfg_data = 1'b0;
        step();
        check("not_mid_configured", b_configured, 0);
        b_cfg_data = 1'b1;
        step();
        b_cfg_valid = 1'b0;
        check("not_configured", b_configured, 1);
        check("not_cfg_ready", b_cfg_ready, 0);
        b_in_valid = 1'b1; b_in_data = 1'b0;
        step();
        check("not_v0", b_out_valid, 1);
        check("not_d0", b_out_data, 1);
        b_in_data = 1'b1;
        step();
        check("not_v1", b_out_valid, 1);
        check("not_d1", b_out_data, 0);
        b_in_valid = 1'b0;
        step();
        check("not_idle_valid", b_out_valid, 0);
        check("not_idle_hold", b_out_data, 0);

        // ch1 = AND, ch0 = XOR, loaded with gaps
        t1 = 8'b1000_0110;
        load(t1, 2, 1'b0);
        for (int v = 0; v < 16; v++) begin
            in_valid = 1'b1;
            in_data  = 4'(v);
            exp_out  = model(t1, in_data);
            step();
            check("sweep_valid", out_valid, 1);
            check("sweep_data", out_data, exp_out);
        end
        in_valid = 1'b0;
        step();
        check("idle_valid", out_valid, 0);
        check("idle_hold", out_data, exp_out);

        // config beats in RUN are ignored
        cfg_valid = 1'b1; cfg_data = 1'b1;
        for (int k = 0; k < 3; k++) step();
        cfg_valid = 1'b0;
        check("run_cfg_ignored", configured, 1);
        run_random(t1, 150);

        // clear with a same-cycle data beat, reload with in_valid held high
        t2 = 8'($urandom);
        in_valid = 1'b1; in_data = 4'($urandom); cfg_clear = 1'b1;
        step();
        cfg_clear = 1'b0;
        check("clr_out_valid", out_valid, 0);
        check("clr_cfg_ready", cfg_ready, 1);
        check("clr_configured", configured, 0);
        check("clr_in_ready", in_ready, 0);
        check("clr_hold_data", out_data, exp_out);
        load(t2, 0, 1'b1);
        exp_out = model(t2, in_data);
        step();
        check("first_run_valid", out_valid, 1);
        check("first_run_data", out_data, exp_out);
        in_valid = 1'b0;
        run_random(t2, 100);

        // async reset part-way through a reload
        t3 = 8'($urandom);
        cfg_clear = 1'b1;
        step();
        cfg_clear = 1'b0;
        for (int i = 7; i >= 5; i--) begin
            cfg_valid = 1'b1; cfg_data = t3[i];
            step();
        end
        cfg_valid = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        exp_out = '0;
        check_reset_a();
        @(posedge clk);
        #1 rst = 1'b0;
        load(t3, 1, 1'b0);
        run_random(t3, 100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
